// File: rtl/player_control_if.sv
// rtl/player_control_if.sv - projectile spawn request handshake between player and projectile manager
interface player_control_if #(
  parameter int W = 12
) ();
  logic         shot_valid;
  logic         shot_ready;
  logic [W-1:0] shot_x;
  logic [W-1:0] shot_y;
  logic [1:0]   shot_dir;

  modport master (output shot_valid, output shot_x, output shot_y, output shot_dir, input shot_ready);
  modport slave  (input shot_valid, input shot_x, input shot_y, input shot_dir, output shot_ready);
endinterface

// File: rtl/player_control.sv
// rtl/player_control.sv - per-player keycode decode, frame-stepped clamped motion, facing and cooled-down fire requests
module player_control #(
  parameter int         KEYS     = 4,
  parameter int         W        = 12,
  parameter int         STEP     = 2,
  parameter int         X_MIN    = 64,
  parameter int         X_MAX    = 3136,
  parameter int         Y_MIN    = 64,
  parameter int         Y_MAX    = 2336,
  parameter int         X_INIT   = 700,
  parameter int         Y_INIT   = 700,
  parameter int         COOLDOWN = 30,
  parameter logic [7:0] KEY_UP   = 8'h1A,
  parameter logic [7:0] KEY_DN   = 8'h16,
  parameter logic [7:0] KEY_LT   = 8'h04,
  parameter logic [7:0] KEY_RT   = 8'h07,
  parameter logic [7:0] AIM_UP   = 8'h52,
  parameter logic [7:0] AIM_DN   = 8'h51,
  parameter logic [7:0] AIM_LT   = 8'h50,
  parameter logic [7:0] AIM_RT   = 8'h4F,
  parameter logic [7:0] KEY_FIRE = 8'h2C
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_vs,
  input  logic [8*KEYS-1:0] keycode,
  output logic [W-1:0]      x,
  output logic [W-1:0]      y,
  output logic [1:0]        dir,
  output logic              moving,
  player_control_if.master  shot
);
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  // Two extra bits keep the signed sum from wrapping near either end of the W-bit range.
  localparam logic signed [W+1:0] STEP_S = (W+2)'(STEP);
  localparam logic signed [W+1:0] XMIN_S = (W+2)'(X_MIN);
  localparam logic signed [W+1:0] XMAX_S = (W+2)'(X_MAX);
  localparam logic signed [W+1:0] YMIN_S = (W+2)'(Y_MIN);
  localparam logic signed [W+1:0] YMAX_S = (W+2)'(Y_MAX);

  typedef enum logic [1:0] {READY, PEND, COOL} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            vs_q;
  logic            tick;
  logic            shot_valid_r;
  logic [W-1:0]    shot_x_r;
  logic [W-1:0]    shot_y_r;
  logic [1:0]      shot_dir_r;

  logic up, dn, lt, rt, aim_up, aim_dn, aim_lt, aim_rt, fire;
  logic signed [W+1:0] dx, dy, sx, sy;
  logic [W-1:0]        nx, ny;
  logic [1:0]          ndir;

  function automatic logic pressed(input logic [8*KEYS-1:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < KEYS; i++) begin
      if (kc[8*i +: 8] != 8'h00 && kc[8*i +: 8] == code) hit = 1'b1;
    end
    return hit;
  endfunction

  assign up     = pressed(keycode, KEY_UP);
  assign dn     = pressed(keycode, KEY_DN);
  assign lt     = pressed(keycode, KEY_LT);
  assign rt     = pressed(keycode, KEY_RT);
  assign aim_up = pressed(keycode, AIM_UP);
  assign aim_dn = pressed(keycode, AIM_DN);
  assign aim_lt = pressed(keycode, AIM_LT);
  assign aim_rt = pressed(keycode, AIM_RT);
  assign fire   = pressed(keycode, KEY_FIRE);

  assign tick = frame_vs & ~vs_q;

  always_comb begin
    dx = '0;
    dy = '0;
    if (rt && !lt) dx = STEP_S;
    else if (lt && !rt) dx = -STEP_S;
    if (dn && !up) dy = STEP_S;
    else if (up && !dn) dy = -STEP_S;
    sx = $signed({2'b00, x}) + dx;
    sy = $signed({2'b00, y}) + dy;
    if (sx < XMIN_S)      nx = W'(X_MIN);
    else if (sx > XMAX_S) nx = W'(X_MAX);
    else                  nx = sx[W-1:0];
    if (sy < YMIN_S)      ny = W'(Y_MIN);
    else if (sy > YMAX_S) ny = W'(Y_MAX);
    else                  ny = sy[W-1:0];
    // Facing codes: 0 N, 1 S, 2 E, 3 W; aim keys override movement keys.
    ndir = dir;
    if (aim_rt || aim_lt || aim_dn || aim_up) begin
      if (aim_rt)      ndir = 2'd2;
      else if (aim_lt) ndir = 2'd3;
      else if (aim_dn) ndir = 2'd1;
      else             ndir = 2'd0;
    end else if (rt || dn || lt || up) begin
      if (rt)      ndir = 2'd2;
      else if (dn) ndir = 2'd1;
      else if (lt) ndir = 2'd3;
      else         ndir = 2'd0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q         <= 1'b0;
      x            <= W'(X_INIT);
      y            <= W'(Y_INIT);
      dir          <= 2'd0;
      moving       <= 1'b0;
      state        <= READY;
      count        <= '0;
      shot_valid_r <= 1'b0;
      shot_x_r     <= '0;
      shot_y_r     <= '0;
      shot_dir_r   <= 2'd0;
    end else begin
      vs_q <= frame_vs;
      if (tick) begin
        x      <= nx;
        y      <= ny;
        dir    <= ndir;
        moving <= (nx != x) || (ny != y);
      end
      case (state)
        READY: if (tick && fire) begin
          shot_x_r     <= x;
          shot_y_r     <= y;
          shot_dir_r   <= dir;
          shot_valid_r <= 1'b1;
          state        <= PEND;
        end
        PEND: if (shot_ready_q()) begin
          shot_valid_r <= 1'b0;
          if (COOLDOWN > 0) begin
            state <= COOL;
            count <= CW'(COOLDOWN);
          end else begin
            state <= READY;
          end
        end
        COOL: if (tick) begin
          count <= count - CW'(1);
          if (count == CW'(1)) state <= READY;
        end
        default: state <= READY;
      endcase
    end
  end

  function automatic logic shot_ready_q();
    return shot.shot_ready;
  endfunction

  assign shot.shot_valid = shot_valid_r;
  assign shot.shot_x     = shot_x_r;
  assign shot.shot_y     = shot_y_r;
  assign shot.shot_dir   = shot_dir_r;
endmodule

// File: tb/tb_player_control.sv
// tb/tb_player_control.sv - randomized bench for player_control against a frame-level reference model
module tb_player_control;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        fvs;
  logic        rdy;
  logic [31:0] kc;

  always #5 clk = ~clk;

  player_control_if #(.W(12)) sa ();
  player_control_if #(.W(12)) sb ();
  player_control_if #(.W(12)) sc ();

  logic [2:0][11:0] ox, oy, osx, osy;
  logic [2:0][1:0]  od, osd;
  logic [2:0]       om, osv;

  player_control u_a (.Clk(clk), .Reset_n(rst_n), .frame_vs(fvs), .keycode(kc),
                      .x(ox[0]), .y(oy[0]), .dir(od[0]), .moving(om[0]), .shot(sa));
  player_control #(.X_INIT(3135), .Y_INIT(65)) u_b (.Clk(clk), .Reset_n(rst_n), .frame_vs(fvs), .keycode(kc),
                      .x(ox[1]), .y(oy[1]), .dir(od[1]), .moving(om[1]), .shot(sb));
  player_control #(.COOLDOWN(0), .X_INIT(65), .Y_INIT(2335)) u_c (.Clk(clk), .Reset_n(rst_n), .frame_vs(fvs), .keycode(kc),
                      .x(ox[2]), .y(oy[2]), .dir(od[2]), .moving(om[2]), .shot(sc));

  assign sa.shot_ready = rdy;
  assign sb.shot_ready = rdy;
  assign sc.shot_ready = rdy;
  assign osv = {sc.shot_valid, sb.shot_valid, sa.shot_valid};
  assign osx = {sc.shot_x, sb.shot_x, sa.shot_x};
  assign osy = {sc.shot_y, sb.shot_y, sa.shot_y};
  assign osd = {sc.shot_dir, sb.shot_dir, sa.shot_dir};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: positions as plain integers, a pending flag and a remaining-cooldown tick count.
  int p_xi[3] = '{700, 3135, 65};
  int p_yi[3] = '{700, 65, 2335};
  int p_cd[3] = '{30, 30, 0};
  int mx[3], my[3], md[3], mm[3], mc[3], msx[3], msy[3], msd[3];
  bit mp[3];
  bit mvsq;
  int tick_no = 0;
  bit rec = 0;
  int qa[$], qc[$];

  function automatic bit key(input logic [7:0] code);
    for (int s = 0; s < 4; s++) if (kc[8*s +: 8] == code) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int clamp(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = p_xi[i]; my[i] = p_yi[i]; md[i] = 0; mm[i] = 0;
      mp[i] = 0; mc[i] = 0; msx[i] = 0; msy[i] = 0; msd[i] = 0;
    end
    mvsq = 0;
  endtask

  task automatic model_clk();
    bit tick;
    int dx, dy;
    if (!rst_n) return;
    tick = fvs && !mvsq;
    mvsq = fvs;
    if (tick) tick_no++;
    dx = 2 * (int'(key(8'h07)) - int'(key(8'h04)));
    dy = 2 * (int'(key(8'h16)) - int'(key(8'h1A)));
    for (int i = 0; i < 3; i++) begin
      bit p0;
      int c0, nx, ny;
      p0 = mp[i];
      c0 = mc[i];
      if (p0 && rdy) begin mp[i] = 0; mc[i] = p_cd[i]; end
      if (tick) begin
        if (!p0 && c0 == 0 && key(8'h2C)) begin
          mp[i] = 1; msx[i] = mx[i]; msy[i] = my[i]; msd[i] = md[i];
        end else if (!p0 && c0 > 0) begin
          mc[i] = c0 - 1;
        end
        nx = clamp(mx[i] + dx, 64, 3136);
        ny = clamp(my[i] + dy, 64, 2336);
        mm[i] = (nx != mx[i] || ny != my[i]) ? 1 : 0;
        mx[i] = nx; my[i] = ny;
        if (key(8'h4F)) md[i] = 2;
        else if (key(8'h50)) md[i] = 3;
        else if (key(8'h51)) md[i] = 1;
        else if (key(8'h52)) md[i] = 0;
        else if (key(8'h07)) md[i] = 2;
        else if (key(8'h16)) md[i] = 1;
        else if (key(8'h04)) md[i] = 3;
        else if (key(8'h1A)) md[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("x%0d", i), int'(ox[i]), mx[i]);
      check($sformatf("y%0d", i), int'(oy[i]), my[i]);
      check($sformatf("dir%0d", i), int'(od[i]), md[i]);
      check($sformatf("moving%0d", i), int'(om[i]), mm[i]);
      check($sformatf("shot_valid%0d", i), int'(osv[i]), int'(mp[i]));
      check($sformatf("shot_x%0d", i), int'(osx[i]), msx[i]);
      check($sformatf("shot_y%0d", i), int'(osy[i]), msy[i]);
      check($sformatf("shot_dir%0d", i), int'(osd[i]), msd[i]);
    end
  endtask

  task automatic do_cycle();
    if (rec && osv[0] && rdy) qa.push_back(tick_no);
    if (rec && osv[2] && rdy) qc.push_back(tick_no);
    @(posedge clk);
    model_clk();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick_frame(input int n);
    for (int f = 0; f < n; f++) begin
      fvs = 1'b1;
      do_cycle();
      fvs = 1'b0;
      for (int c = 0; c < 1 + $urandom_range(0, 2); c++) do_cycle();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_x%0d", i), int'(ox[i]), p_xi[i]);
      check($sformatf("rst_y%0d", i), int'(oy[i]), p_yi[i]);
      check($sformatf("rst_dir%0d", i), int'(od[i]), 0);
      check($sformatf("rst_moving%0d", i), int'(om[i]), 0);
      check($sformatf("rst_valid%0d", i), int'(osv[i]), 0);
      check($sformatf("rst_shot_x%0d", i), int'(osx[i]), 0);
    end
    model_reset();
    @(negedge clk);
    do_cycle();
    do_cycle();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_kc();
    logic [7:0] pool[10];
    logic [31:0] k;
    pool = '{8'h00, 8'h1A, 8'h16, 8'h04, 8'h07, 8'h52, 8'h51, 8'h50, 8'h4F, 8'h2C};
    for (int s = 0; s < 4; s++) begin
      int r;
      r = $urandom_range(0, 11);
      k[8*s +: 8] = (r < 10) ? pool[r] : ((r == 10) ? 8'h00 : 8'($urandom_range(1, 255)));
    end
    return k;
  endfunction

  initial begin
    rst_n = 1'b0; fvs = 1'b0; rdy = 1'b0; kc = '0;
    model_reset();
    @(negedge clk);
    do_reset();

    tick_frame(5);
    check("idle_x", int'(ox[0]), 700);
    check("idle_valid", int'(osv[0]), 0);

    kc = 32'h0007_0000;
    tick_frame(10);
    check("rt10_x", int'(ox[0]), 720);
    check("rt10_dir", int'(od[0]), 2);
    check("rt10_moving", int'(om[0]), 1);
    check("edge_x", int'(ox[1]), 3136);
    check("edge_moving", int'(om[1]), 0);

    kc = 32'h001A_1607;
    tick_frame(1);
    check("cancel_x", int'(ox[0]), 722);
    check("cancel_y", int'(oy[0]), 700);
    check("cancel_dir", int'(od[0]), 2);
    kc = 32'h501A_1607;
    tick_frame(1);
    check("aim_x", int'(ox[0]), 724);
    check("aim_dir", int'(od[0]), 3);

    kc = 32'h0000_2C07;
    rdy = 1'b0;
    tick_frame(3);
    check("pend_valid", int'(osv[0]), 1);
    check("pend_shot_x", int'(osx[0]), 724);
    check("pend_shot_dir", int'(osd[0]), 3);
    check("pend_x", int'(ox[0]), 730);
    rdy = 1'b1;
    do_cycle();
    rdy = 1'b0;
    check("accept_valid", int'(osv[0]), 0);

    kc = 32'h0000_002C;
    rdy = 1'b1;
    rec = 1'b1;
    tick_frame(100);
    rec = 1'b0;
    rdy = 1'b0;
    check("cool_shots", (qa.size() >= 3) ? 1 : 0, 1);
    for (int i = 1; i < qa.size(); i++) check("cool_gap", qa[i] - qa[i-1], 31);
    check("nocool_shots", (qc.size() >= 50) ? 1 : 0, 1);
    for (int i = 1; i < 6 && i < qc.size(); i++) check("nocool_gap", qc[i] - qc[i-1], 1);

    do_reset();
    kc = 32'h0000_002C;
    tick_frame(1);
    check("pend_before_rst", int'(osv[0]), 1);
    do_reset();
    rdy = 1'b1;
    tick_frame(1);
    rdy = 1'b0;
    check("cool_before_rst", int'(osv[0]), 0);
    do_reset();
    tick_frame(1);
    check("fire_after_rst", int'(osv[0]), 1);

    for (int f = 0; f < 500; f++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      kc = rand_kc();
      fvs = 1'b1;
      for (int c = 0; c < 1 + $urandom_range(0, 1); c++) begin
        rdy = ($urandom_range(0, 2) != 0);
        do_cycle();
      end
      fvs = 1'b0;
      for (int c = 0; c < 1 + $urandom_range(0, 2); c++) begin
        rdy = ($urandom_range(0, 2) != 0);
        do_cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/player_control.md
Name: player_control

Overview:
Per-player motion, facing and fire controller. It generalises the two-player hard-wired movement logic into one instance per player. Decodes a parametrised N-slot keycode rollover, moves the player in saturating steps once per video frame, tracks facing with aim-key override, and issues projectile spawn requests through a valid/ready handshake gated by a frame-count cooldown. Sits between the USB/PS2 keycode sources and the projectile manager and sprite renderer.

Parameters:
KEYS, 4, number of 8-bit keycode rollover slots
W, 12, coordinate width (bits)
STEP, 2, pixels moved per frame per axis
X_MIN, 64, lowest legal x; X_MAX, 3136, highest legal x
Y_MIN, 64, lowest legal y; Y_MAX, 2336, highest legal y
X_INIT, 700, reset x; Y_INIT, 700, reset y
COOLDOWN, 30, frames after an accepted shot before the next shot may be requested (0 allowed)
KEY_UP/KEY_DN/KEY_LT/KEY_RT, 8'h1A/8'h16/8'h04/8'h07, movement keycodes
AIM_UP/AIM_DN/AIM_LT/AIM_RT, 8'h52/8'h51/8'h50/8'h4F, aim-only keycodes
KEY_FIRE, 8'h2C, fire keycode (all keycode parameters nonzero)

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
frame_vs  in  1  VGA_VS, synchronous to Clk; each rising edge is one frame tick
keycode  in  8*KEYS  rollover slots, slot i = [8i+7:8i], 8'h00 = empty
x  out  W  player x
y  out  W  player y
dir  out  2  facing: 0 N, 1 S, 2 E, 3 W
moving  out  1  position changed on the last tick
shot_valid  out  1  spawn request pending
shot_ready  in  1  projectile manager accepts the request
shot_x  out  W  spawn x
shot_y  out  W  spawn y
shot_dir  out  2  spawn direction

Behaviour:
- Reset (asynchronous assert, synchronous release): x=X_INIT, y=Y_INIT, dir=0, moving=0, shot_valid=0, shot_x/y/dir=0, FSM=READY, cooldown count=0, vs_q=0.
- Tick: registered vs_q; tick = frame_vs & ~vs_q. Position, dir, moving and cooldown update only on tick cycles. The handshake is evaluated every cycle.
- Key decode: a key is pressed if any slot equals its code. Empty slots (00) never match. Decode is combinational from the current keycode.
- Motion: dx = STEP*(RT-LT) and dy = STEP*(DN-UP), computed signed in W+2 bits. Opposing keys cancel. Diagonals are allowed.
- Next position is clamped to [MIN,MAX] per axis. It saturates, and does not freeze, at the edge. Axes are independent.
- moving <= (next != current) on each tick.
- Facing on tick: if any aim key is pressed, dir follows aim keys with priority RT>LT>DN>UP. Else if any move key is pressed, dir follows with priority RT>DN>LT>UP. Otherwise dir holds.
- Fire FSM states:
  - READY: on a tick with FIRE pressed, latch shot_x/y/dir from the pre-update x/y/dir and go to PEND.
  - PEND: shot_valid=1 and the payload holds stable. On a valid&ready cycle: go to COOL with count=COOLDOWN if COOLDOWN>0, else go to READY. Ticks during PEND still move the player but do not alter the payload.
  - COOL: count decrements on each tick. A tick that finds count==1 goes to READY. The next tick may then fire again.
- Holding FIRE gives auto-fire at an interval of COOLDOWN+1 ticks or more (plus any ready stall). Presses made while in PEND or COOL are not queued.
- shot_ready while not PEND is ignored.
- A tick and shot_ready in the same cycle are both honoured.
- Reset mid-PEND drops the request (shot_valid=0 immediately on assert).
- Clamp arithmetic must not wrap when X_MIN<STEP or X_MAX>2^W-1-STEP.

Test Plan:
- Reset, no keys, 5 ticks -> x=700, y=700, dir=0, moving=0, shot_valid=0 throughout.
- Slot2=8'h07 held 10 ticks -> x=720, y=700, dir=2, moving=1; the same held with x preset near X_MAX at 3135 -> x=3136 then stays, moving=0.
- Slots 8'h1A+8'h16+8'h07 for 1 tick -> y unchanged, x+2, dir=2 (RT beats DN). Adding 8'h50 -> dir=3 with x still +2.
- FIRE held, shot_ready=0 for 3 ticks -> shot_valid=1 with payload frozen at the first-tick position while x/y keep moving. Then ready=1 for 1 cycle -> shot_valid=0 next cycle.
- COOLDOWN=30, FIRE held, ready=1 -> accepted shots spaced exactly 31 ticks apart. COOLDOWN=0 -> one shot per tick.
- Assert Reset_n=0 mid-PEND and mid-COOL -> outputs return to reset values immediately. After release, a FIRE tick requests immediately.
